// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Package     : mips_pkg                                                   |
// | Description : Shared types and constants for the MIPS fetch front end:   |
// |               fetch FSM state encoding, NOP word, reset PC and the       |
// |               OP/FUNCT field positions of an instruction word.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  // Fetch sequencer states: FETCH issues/awaits a request, KILL waits out a
  // request whose data is no longer wanted, HOLD parks a fetched word while
  // decode is stalled.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    KILL  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // sll $0,$0,0 - presented whenever IF/ID carries no real instruction
  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

  // Text-segment base loaded into the PC by reset
  localparam logic [31:0] c_RESET_PC  = 32'h0040_0000;

  // Sequential instruction stride in bytes
  localparam logic [31:0] c_PC_STEP   = 32'd4;

  // Instruction field positions consumed by the decode-stage control unit
  localparam int c_OP_MSB    = 31;
  localparam int c_OP_LSB    = 26;
  localparam int c_FUNCT_MSB = 5;
  localparam int c_FUNCT_LSB = 0;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage : mips_pkg

`default_nettype wire

// File: rtl/instruction_fetch_unit_if_id_reg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : if_id_reg                                                  |
// | Description : IF/ID pipeline register. Holds instruction word, its       |
// |               PC+4 and a valid flag. Flush beats hold beats load; with    |
// |               nothing to load and no hold it drops to a NOP bubble.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_flush,
  input  logic        i_hold,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;

  // Pipeline register update. The PC+4 field is left untouched on flush or
  // bubble: it is only meaningful while the valid flag is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (i_hold) begin
      r_valid <= r_valid;
      r_instr <= r_instr;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end else begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule : if_id_reg

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : instruction_fetch_unit                                     |
// | Description : PC generation, single-outstanding req/ack instruction      |
// |               fetch and IF/ID register for the MIPS core. Handles decode |
// |               stall (one-word park buffer) and branch/jump redirect with |
// |               discard of the in-flight wrong-path fetch.                 |
// |               Optional build macro FETCH_PERF_CNT_EN adds wrapping        |
// |               perf_fetched / perf_stall / perf_killed counters.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_RESET_PC,
  parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        id_stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [5:0]  if_op,
  output logic [5:0]  if_func,
  output logic [31:0] if_pc4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_killed
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_reqAddr;
  logic         r_imemReq;
  logic [31:0]  r_bufInstr;
  logic [31:0]  r_bufPc4;

  fetch_state_t w_stateNext;
  logic [31:0]  w_pcNext;
  logic [31:0]  w_redirTarget;
  logic         w_blocked;
  logic         w_bufLoad;
  logic         w_idLoad;
  logic [31:0]  w_idInstr;
  logic [31:0]  w_idPc4;
  logic         w_killEvent;
  logic         w_ifValid;

  assign w_redirTarget = alignWord(redir_pc);
  assign w_blocked     = w_ifValid && id_stall;

  // Next-state, next-PC and IF/ID load selection; redirect beats stall beats load
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_bufLoad   = 1'b0;
    w_idLoad    = 1'b0;
    w_idInstr   = r_bufInstr;
    w_idPc4     = r_bufPc4;
    w_killEvent = 1'b0;
    case (r_state)
      FETCH: begin
        if (redir_valid) begin
          // Wrong-path fetch: drop it now if it completes, else wait it out
          w_pcNext    = w_redirTarget;
          w_killEvent = 1'b1;
          if (!imem_ack) begin
            w_stateNext = KILL;
          end
        end else if (imem_ack) begin
          w_pcNext = r_pc + c_PC_STEP;
          if (w_blocked) begin
            w_bufLoad   = 1'b1;
            w_stateNext = HOLD;
          end else begin
            w_idLoad  = 1'b1;
            w_idInstr = imem_rdata;
            w_idPc4   = r_reqAddr + c_PC_STEP;
          end
        end
      end
      KILL: begin
        if (redir_valid) begin
          w_pcNext = w_redirTarget;
        end
        if (imem_ack) begin
          w_stateNext = FETCH;
        end
      end
      HOLD: begin
        if (redir_valid) begin
          w_pcNext    = w_redirTarget;
          w_killEvent = 1'b1;
          w_stateNext = FETCH;
        end else if (!w_blocked) begin
          w_idLoad    = 1'b1;
          w_stateNext = FETCH;
        end
      end
      default: begin
        w_stateNext = FETCH;
      end
    endcase
  end

  // Fetch sequencer: state, PC, request address/strobe and park buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_reqAddr  <= RESET_PC;
      r_imemReq  <= 1'b1;
      r_bufInstr <= NOP_INSTR;
      r_bufPc4   <= 32'd0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_imemReq <= (w_stateNext != HOLD);
      // A request address is only (re)latched when a request starts; in
      // KILL the old address must stay on the bus until its ack.
      if (w_stateNext == FETCH) begin
        r_reqAddr <= w_pcNext;
      end
      if (w_bufLoad) begin
        r_bufInstr <= imem_rdata;
        r_bufPc4   <= r_reqAddr + c_PC_STEP;
      end
    end
  end

  assign imem_req  = r_imemReq;
  assign imem_addr = r_reqAddr;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifId (
    .clk     (clk),
    .reset   (reset),
    .i_flush (redir_valid),
    .i_hold  (w_blocked),
    .i_load  (w_idLoad),
    .i_instr (w_idInstr),
    .i_pc4   (w_idPc4),
    .o_valid (w_ifValid),
    .o_instr (if_instr),
    .o_pc4   (if_pc4)
  );

  assign if_valid = w_ifValid;
  assign if_op    = if_instr[c_OP_MSB:c_OP_LSB];
  assign if_func  = if_instr[c_FUNCT_MSB:c_FUNCT_LSB];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perfFetched;
  logic [31:0] r_perfStall;
  logic [31:0] r_perfKilled;

  // Wrapping event counters: IF/ID loads, blocked cycles, redirect-discarded fetches
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perfFetched <= 32'd0;
      r_perfStall   <= 32'd0;
      r_perfKilled  <= 32'd0;
    end else begin
      if (w_idLoad) begin
        r_perfFetched <= r_perfFetched + 32'd1;
      end
      if (w_blocked) begin
        r_perfStall <= r_perfStall + 32'd1;
      end
      if (w_killEvent) begin
        r_perfKilled <= r_perfKilled + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perfFetched;
  assign perf_stall   = r_perfStall;
  assign perf_killed  = r_perfKilled;
`endif

endmodule : instruction_fetch_unit

`default_nettype wire
